// File: rtl/exec_core.sv
// exec_core: single-cycle decode + 8x16 register file + 16-bit ALU.
// Define EXEC_CORE_SHIFT_EN to add the SLL/SRL opcodes (0x08/0x09).
module exec_core (
  input  logic         CLK,
  input  logic         RST,
  input  logic [15:0]  instr,
  output logic         halted,
  output logic [15:0]  alu_result,
  output logic [127:0] reg_state
);
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  logic [6:0]           opcode;
  logic [REG_IDX_W-1:0] rs, rt, rd;
  logic                 reg_write_en, itype;
  logic [3:0]           alu_op;
  logic [DATA_W-1:0]    imm, a, b;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  assign opcode = instr[15:9];
  assign rs     = instr[8:6];
  assign rt     = instr[5:3];
  assign rd     = instr[2:0];
  assign imm    = {{(DATA_W-3){rs[2]}}, rs};
  always_comb begin
    halted = opcode == 7'h00;
`ifdef EXEC_CORE_SHIFT_EN
    reg_write_en = opcode >= 7'h01 && opcode <= 7'h09;
`else
    reg_write_en = opcode >= 7'h01 && opcode <= 7'h07;
`endif
    itype  = opcode == 7'h06 || opcode == 7'h07;
    // Non-writing opcodes map to op 0 so the ALU output is a quiet zero.
    alu_op = reg_write_en ? opcode[3:0] : 4'h0;
  end
  assign a = itype ? imm : regs_q[rs];
  assign b = regs_q[rt];
  always_comb begin
    alu_result = (alu_op == OP_ADD || alu_op == OP_ADDI) ? a + b :
                 alu_op == OP_SUB ? a - b :
                 alu_op == OP_AND ? a & b :
                 alu_op == OP_OR  ? a | b :
                 alu_op == OP_XOR ? a ^ b :
                 alu_op == OP_LI  ? a :
`ifdef EXEC_CORE_SHIFT_EN
                 alu_op == OP_SLL ? b << a[3:0] :
                 alu_op == OP_SRL ? b >> a[3:0] :
`endif
                 '0;
  end
  always_comb begin
    regs_d = regs_q;
    if (reg_write_en) regs_d[rd] = alu_result;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_state[g*DATA_W +: DATA_W] = regs_q[g];
  end
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed self-checking bench for exec_core.
module tb_exec_core;
  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [15:0]  instr = 16'h0000;
  logic         halted;
  logic [15:0]  alu_result;
  logic [127:0] reg_state;
  int checks = 0;
  int failures = 0;

  exec_core dut (
    .CLK(CLK), .RST(RST), .instr(instr),
    .halted(halted), .alu_result(alu_result), .reg_state(reg_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] s, t, d);
    return {op, s, t, d};
  endfunction

  function automatic logic [15:0] rg(input int i);
    return reg_state[16*i +: 16];
  endfunction

  task automatic step(input logic [15:0] i);
    instr = i;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #2 RST = 1'b1;
    #1;
    checks++;
    if (reg_state !== '0) begin failures++; $display("FAIL reset_async got %h exp 0", reg_state); end
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got %b exp 1", halted); end
    @(posedge CLK);
    #1 RST = 1'b0;
    step(enc(7'h07, 3'd3, 3'd0, 3'd1));
    checks++;
    if (rg(1) !== 16'h0003) begin failures++; $display("FAIL li_r1_3 got %h exp 0003", rg(1)); end
    instr = enc(7'h07, 3'd7, 3'd0, 3'd2);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (reg_state !== '0) begin failures++; $display("FAIL reset_midcycle got %h exp 0", reg_state); end
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halted_under_rst got %b exp 0", halted); end
    @(posedge CLK);
    #1;
    checks++;
    if (rg(2) !== 16'h0000) begin failures++; $display("FAIL reset_write_discard got %h exp 0000", rg(2)); end
    RST = 1'b0;
  endtask

  task automatic test_li_addi;
    step(16'h0E01);
    checks++;
    if (rg(1) !== 16'h0000) begin failures++; $display("FAIL li_zero got %h exp 0000", rg(1)); end
    step(enc(7'h07, 3'd7, 3'd0, 3'd2));
    checks++;
    if (rg(2) !== 16'hFFFF) begin failures++; $display("FAIL li_neg1 got %h exp ffff", rg(2)); end
    step(enc(7'h06, 3'd3, 3'd2, 3'd3));
    checks++;
    if (rg(3) !== 16'h0002) begin failures++; $display("FAIL addi got %h exp 0002", rg(3)); end
    step(enc(7'h07, 3'd4, 3'd0, 3'd5));
    checks++;
    if (rg(5) !== 16'hFFFC) begin failures++; $display("FAIL li_neg4 got %h exp fffc", rg(5)); end
  endtask

  task automatic test_rtype_wrap;
    step(enc(7'h07, 3'd1, 3'd0, 3'd4));
    for (int i = 0; i < 15; i++) step(enc(7'h01, 3'd4, 3'd4, 3'd4));
    checks++;
    if (rg(4) !== 16'h8000) begin failures++; $display("FAIL double_chain got %h exp 8000", rg(4)); end
    step(enc(7'h07, 3'd1, 3'd0, 3'd2));
    step(enc(7'h02, 3'd4, 3'd2, 3'd1));
    checks++;
    if (rg(1) !== 16'h7FFF) begin failures++; $display("FAIL sub_build got %h exp 7fff", rg(1)); end
    step(enc(7'h01, 3'd1, 3'd2, 3'd3));
    checks++;
    if (rg(3) !== 16'h8000) begin failures++; $display("FAIL add_wrap got %h exp 8000", rg(3)); end
    step(enc(7'h02, 3'd2, 3'd1, 3'd3));
    checks++;
    if (rg(3) !== 16'h8002) begin failures++; $display("FAIL sub_wrap got %h exp 8002", rg(3)); end
    step(enc(7'h05, 3'd1, 3'd1, 3'd3));
    checks++;
    if (rg(3) !== 16'h0000) begin failures++; $display("FAIL xor_self got %h exp 0000", rg(3)); end
    step(enc(7'h03, 3'd1, 3'd4, 3'd3));
    checks++;
    if (rg(3) !== 16'h0000) begin failures++; $display("FAIL and got %h exp 0000", rg(3)); end
    step(enc(7'h04, 3'd1, 3'd4, 3'd3));
    checks++;
    if (rg(3) !== 16'hFFFF) begin failures++; $display("FAIL or got %h exp ffff", rg(3)); end
  endtask

  task automatic test_read_before_write;
    step(enc(7'h07, 3'd3, 3'd0, 3'd1));
    step(enc(7'h07, 3'd2, 3'd0, 3'd6));
    step(enc(7'h01, 3'd1, 3'd6, 3'd1));
    instr = enc(7'h01, 3'd1, 3'd1, 3'd1);
    #1;
    checks++;
    if (alu_result !== 16'd10) begin failures++; $display("FAIL rbw_alu got %h exp 000a", alu_result); end
    checks++;
    if (rg(1) !== 16'd5) begin failures++; $display("FAIL rbw_pre got %h exp 0005", rg(1)); end
    @(posedge CLK);
    #1;
    checks++;
    if (rg(1) !== 16'd10) begin failures++; $display("FAIL rbw_post got %h exp 000a", rg(1)); end
  endtask

  task automatic test_halt_nop;
    logic [127:0] snap;
    snap = reg_state;
    instr = 16'h0000;
    #1;
    checks++;
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got %b exp 1", halted); end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (reg_state !== snap) begin failures++; $display("FAIL halt_hold got %h exp %h", reg_state, snap); end
    instr = enc(7'h7F, 3'd1, 3'd1, 3'd2);
    #1;
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL nop_halted got %b exp 0", halted); end
    @(posedge CLK);
    #1;
    checks++;
    if (reg_state !== snap) begin failures++; $display("FAIL nop_nowrite got %h exp %h", reg_state, snap); end
  endtask

  task automatic test_shift;
    step(enc(7'h07, 3'd2, 3'd0, 3'd1));
    step(enc(7'h01, 3'd1, 3'd1, 3'd1));
    step(enc(7'h07, 3'd3, 3'd0, 3'd2));
    step(enc(7'h07, 3'd0, 3'd0, 3'd3));
    step(enc(7'h07, 3'd7, 3'd0, 3'd5));
`ifdef EXEC_CORE_SHIFT_EN
    step(enc(7'h08, 3'd1, 3'd2, 3'd3));
    checks++;
    if (rg(3) !== 16'h0030) begin failures++; $display("FAIL sll got %h exp 0030", rg(3)); end
    step(enc(7'h09, 3'd5, 3'd4, 3'd6));
    checks++;
    if (rg(6) !== 16'h0001) begin failures++; $display("FAIL srl got %h exp 0001", rg(6)); end
`else
    instr = enc(7'h08, 3'd1, 3'd2, 3'd3);
    #1;
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL sll_off_halted got %b exp 0", halted); end
    @(posedge CLK);
    #1;
    checks++;
    if (rg(3) !== 16'h0000) begin failures++; $display("FAIL sll_off_nowrite got %h exp 0000", rg(3)); end
    step(enc(7'h09, 3'd5, 3'd4, 3'd6));
    checks++;
    if (rg(6) !== 16'h0002) begin failures++; $display("FAIL srl_off_nowrite got %h exp 0002", rg(6)); end
`endif
  endtask

  initial begin
    test_reset;
    test_li_addi;
    test_rtype_wrap;
    test_read_before_write;
    test_halt_nop;
    test_shift;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end
endmodule

// File: doc/exec_core.md
# exec_core

Single-cycle execute core for the little-computer CPU: instruction decode, an 8×16-bit register file and a 16-bit ALU. The fetch stage drives it one instruction per clock. It decodes the instruction, reads two source registers, computes a result and writes it to the destination register on the next rising edge. It also raises `halted` so the fetch stage can freeze its PC.

## Interface

Parameters are fixed for this block and are not overridable.
- `DATA_W`, 16: register and ALU width.
- `NUM_REGS`, 8: number of registers.
- `REG_IDX_W`, 3: register index width.
- `INSTR_W`, 16: instruction width.

Ports (clock and reset first):
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `instr`  in  16  current instruction, held stable by fetch for the whole cycle.
- `halted`  out  1  combinational; high while `instr` is HALT.
- `alu_result`  out  16  combinational ALU output, which is also the write-back data.
- `reg_state`  out  128  all registers, flattened; register i sits at [16i+15:16i].

## Operation

Instruction fields:
- opcode = instr[15:9] (7 bits).
- rs = instr[8:6], rt = instr[5:3], rd = instr[2:0].
- The I-type immediate is the rs field, sign-extended from bit 8 to 16 bits (range −4..+3).

Opcodes (hex). For R-type ops, A = reg[rs] and B = reg[rt]. For I-type ops, A = sext(imm) and B = reg[rt].
- 0x00 HALT: `halted`=1, no write.
- 0x01 ADD: rd ← A+B.
- 0x02 SUB: rd ← A−B.
- 0x03 AND: rd ← A&B.
- 0x04 OR: rd ← A|B.
- 0x05 XOR: rd ← A^B.
- 0x06 ADDI (I-type): rd ← sext(imm)+reg[rt].
- 0x07 LI (I-type): rd ← sext(imm).
- 0x08 SLL: rd ← reg[rt] << reg[rs][3:0]. Only with the shift feature (see Configuration).
- 0x09 SRL: rd ← reg[rt] >> reg[rs][3:0], logical. Only with the shift feature.
- Any other opcode is a NOP: no write, `halted`=0.

Arithmetic rules:
- All arithmetic wraps modulo 2^16.
- No flags and no exceptions.

Decode:
- The control sub-block outputs `halted`, `reg_write_en`, `itype` and `alu_op`.
- `reg_write_en` is 1 only for opcodes 0x01–0x07, plus 0x08–0x09 when the shift feature is compiled in.

Register file:
- Two combinational read ports (rs, rt) and one synchronous write port (rd).
- Every register, including r0, is writable; there is no hardwired zero.

## Timing

- Decode, register read and ALU evaluation are fully combinational: `alu_result` and `halted` are valid in the same cycle `instr` changes.
- The write to rd commits on the rising `CLK` edge when `reg_write_en`=1 and `RST`=0. Latency is one cycle: the result is visible on `reg_state` and the read ports after that edge.
- Reads within a cycle see pre-edge values. If rd equals rs or rt, the instruction uses the old value. There is no write-through bypass.
- Reset:
  - Asserting `RST` clears all registers to 0x0000 immediately, without waiting for a clock edge.
  - While `RST` is high, writes are suppressed.
  - Reset in the middle of a write cycle wins: the register ends at 0.
- `halted` does not depend on `RST`. After reset it reflects only the current `instr`.
- With `instr` held at HALT (0x0000) across any number of edges, register state is unchanged.

## Configuration

- Macro `EXEC_CORE_SHIFT_EN`.
- Defined: opcodes 0x08 (SLL) and 0x09 (SRL) are implemented as specified. The shift amount is reg[rs][3:0]; bits [15:4] are ignored.
- Undefined: 0x08 and 0x09 decode as NOP (no write, `halted`=0), and the shifter is not synthesized.

## Test plan

- Reset: assert `RST` asynchronously, between edges → `reg_state` is all zeros immediately. A write pending in that cycle is discarded.
- LI/ADDI sign extension: `instr`=0x0E01 (LI r1 ← rs field 0) gives r1=0x0000. LI with rs field 3'b111 into r2 gives r2=0xFFFF. ADDI with imm=3, rt=r2, rd=r3 gives r3=0x0002.
- R-type with wrap-around: with r1=0x7FFF and r2=0x0001 → ADD into r3 gives 0x8000; SUB r2−r1 gives 0x8002; XOR r1,r1 gives 0x0000.
- Read-before-write: ADD r1 ← r1+r1 with r1=5 → `alu_result`=10 during the cycle. r1 stays 5 until the edge and is 10 after it.
- HALT: `instr`=0x0000 → `halted`=1 combinationally and no register changes over 3 edges. An undefined opcode 0x7F gives `halted`=0 and no write.
- Shift feature: with the macro defined, r1=4 and r2=0x0003 → SLL gives 0x0030 and SRL of 0x8000 by 15 gives 0x0001. Without the macro, opcode 0x08 leaves rd unchanged.
